// File: rtl/flop_write_arbiter_pkg.sv
// Shared types and default sizing for the flop write arbiter.
// Holds the arbiter state enum and the pointer wrap helper.
package flop_arb_pkg;

  typedef enum logic {IDLE, OWNED} arb_state_t;

  localparam int unsigned NREQ_DEF     = 4;
  localparam int unsigned WIDTH_DEF    = 4;
  localparam int unsigned MAX_LOCK_DEF = 8;

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1) % n;
  endfunction

endpackage

// File: rtl/flop_write_arbiter_if.sv
// Requester-side bundle for the flop write arbiter: requests and write data in,
// grant and shared-register view out.
interface flop_write_arbiter_if
  import flop_arb_pkg::*;
#(
  parameter int unsigned NREQ  = NREQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) ();
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [IDW-1:0]        owner;
  logic                  valid;
  logic [7:0]            wr_count;

  modport master (
    output req, lock, wdata,
    input  gnt, q, owner, valid, wr_count
  );

  modport slave (
    input  req, lock, wdata,
    output gnt, q, owner, valid, wr_count
  );
endinterface

// File: rtl/flop_write_arbiter_rr_pick.sv
// Circular-priority picker: first set request at or after ptr, wrapping mod NREQ.
module rr_pick #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         i_req,
  input  logic [$clog2(NREQ)-1:0] i_ptr,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_any
);
  localparam int unsigned IDW = $clog2(NREQ);

  always_comb begin
    int unsigned    w_cand;
    logic [IDW-1:0] w_c;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = 0;
    w_c    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = (32'(i_ptr) + k) % NREQ;
      w_c    = w_cand[IDW-1:0];
      if (!o_any && i_req[w_c]) begin
        o_any = 1'b1;
        o_idx = w_c;
      end
    end
  end

endmodule

// File: rtl/flop_write_arbiter.sv
// Round-robin owner of one shared enable-flop register, with bounded multi-cycle lock.
// A released owner hands over at the same edge, so back-to-back writers see no bubble.
module flop_write_arbiter
  import flop_arb_pkg::*;
#(
  parameter int unsigned NREQ     = NREQ_DEF,
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEF
) (
  input logic                 clk,
  input logic                 reset,
  flop_write_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(NREQ);
  localparam int unsigned HW  = $clog2(MAX_LOCK + 1);

  arb_state_t       r_state, w_state_nxt;
  logic [IDW-1:0]   r_owner, w_owner_nxt;
  logic [IDW-1:0]   r_ptr, w_ptr_nxt;
  logic [HW-1:0]    r_hold, w_hold_nxt;
  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic [7:0]       r_wr_count;

  logic             w_wr;
  logic             w_keep;
  logic [NREQ-1:0]  w_owner_oh;
  logic [NREQ-1:0]  w_pick_req;
  logic [IDW-1:0]   w_pick_ptr;
  logic [IDW-1:0]   w_ptr_rel;
  logic [IDW-1:0]   w_pick_idx;
  logic             w_pick_any;
  logic [WIDTH-1:0] w_wdata_sel;

  assign w_owner_oh  = NREQ'(1) << r_owner;
  assign w_wr        = (r_state == OWNED) && bus.req[r_owner];
  assign w_keep      = w_wr && bus.lock[r_owner] && ((32'(r_hold) + 32'd1) < MAX_LOCK);
  assign w_ptr_rel   = IDW'(wrap_inc(32'(r_owner), NREQ));
  assign w_wdata_sel = bus.wdata[r_owner*WIDTH +: WIDTH];

  // While owned, the picker already looks past the current owner so a release can re-grant.
  assign w_pick_req = (r_state == OWNED) ? (bus.req & ~w_owner_oh) : bus.req;
  assign w_pick_ptr = (r_state == OWNED) ? w_ptr_rel : r_ptr;

  rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .i_req (w_pick_req),
    .i_ptr (w_pick_ptr),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    unique case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state_nxt = OWNED;
          w_owner_nxt = w_pick_idx;
          w_hold_nxt  = '0;
        end
      end
      OWNED: begin
        if (w_keep) begin
          w_hold_nxt = r_hold + HW'(1);
        end else begin
          w_ptr_nxt  = w_ptr_rel;
          w_hold_nxt = '0;
          if (w_pick_any) begin
            w_owner_nxt = w_pick_idx;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.gnt      = (r_state == OWNED) ? w_owner_oh : '0;
    bus.q        = r_q;
    bus.owner    = r_owner;
    bus.valid    = r_valid;
    bus.wr_count = r_wr_count;
  end

  // The shared register: loads only on a write cycle of the current owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q        <= '0;
      r_valid    <= 1'b0;
      r_wr_count <= '0;
    end else if (w_wr) begin
      r_q        <= w_wdata_sel;
      r_valid    <= 1'b1;
      r_wr_count <= r_wr_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_flop_write_arbiter.sv
// Scoreboard bench: each driven cycle queues the expected post-edge outputs,
// and a negedge monitor pops and compares them.
module tb_flop_write_arbiter;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  typedef struct {
    int         tag;
    logic [3:0] g;
    logic [3:0] qv;
    logic [1:0] ow;
    logic       v;
    logic [7:0] wc;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  flop_write_arbiter_if #(.NREQ(4), .WIDTH(4)) bus ();

  flop_write_arbiter #(
    .NREQ     (4),
    .WIDTH    (4),
    .MAX_LOCK (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc > 1) begin
      n_tests++;
      if ($onehot0(bus.gnt) !== 1'b1) begin
        n_fail++;
        $display("FAIL gnt_onehot cyc=%0d gnt=%b required one-hot or zero", cyc, bus.gnt);
      end
    end
    while (sb.size() > 0 && sb[0].tag < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s never checked (tag %0d, cyc %0d)", sb[0].nm, sb[0].tag, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].tag == cyc) begin
      e = sb.pop_front();
      n_tests++;
      if (bus.gnt !== e.g || bus.q !== e.qv || bus.owner !== e.ow ||
          bus.valid !== e.v || bus.wr_count !== e.wc) begin
        n_fail++;
        $display("FAIL %s cyc=%0d got gnt=%b q=%h owner=%0d valid=%b wr_count=%0d; required gnt=%b q=%h owner=%0d valid=%b wr_count=%0d",
                 e.nm, cyc, bus.gnt, bus.q, bus.owner, bus.valid, bus.wr_count,
                 e.g, e.qv, e.ow, e.v, e.wc);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic rst, input logic [3:0] rq, input logic [3:0] lk,
                      input logic [15:0] wd, input logic [3:0] g, input logic [3:0] qv,
                      input logic [1:0] ow, input logic v, input logic [7:0] wc,
                      input string nm);
    exp_t x;
    reset     = rst;
    bus.req   = rq;
    bus.lock  = lk;
    bus.wdata = wd;
    x.tag = cyc + 1;
    x.g   = g;
    x.qv  = qv;
    x.ow  = ow;
    x.v   = v;
    x.wc  = wc;
    x.nm  = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    bus.req   = '0;
    bus.lock  = '0;
    bus.wdata = '0;
    @(posedge clk);
    #1;

    // Reset, then idle with no requests.
    step(1, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'h0, 2'd0, 0, 8'd0, "reset0");
    step(1, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'h0, 2'd0, 0, 8'd0, "reset1");
    for (int i = 0; i < 10; i++)
      step(0, 4'b0000, 4'b0000, 16'hFFFF, 4'b0000, 4'h0, 2'd0, 0, 8'd0, "idle");

    // Single unlocked write from requester 2.
    step(0, 4'b0100, 4'b0000, 16'h0A00, 4'b0100, 4'h0, 2'd2, 0, 8'd0, "single_gnt");
    step(0, 4'b0100, 4'b0000, 16'h0A00, 4'b0000, 4'hA, 2'd2, 1, 8'd1, "single_wr");
    step(0, 4'b0000, 4'b0000, 16'h0A00, 4'b0000, 4'hA, 2'd2, 1, 8'd1, "single_idle");
    step(1, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'h0, 2'd0, 0, 8'd0, "reset2");

    // All requesting, unlocked: back-to-back rotation.
    step(0, 4'b1111, 4'b0000, 16'h4321, 4'b0001, 4'h0, 2'd0, 0, 8'd0, "rr_0");
    step(0, 4'b1111, 4'b0000, 16'h4321, 4'b0010, 4'h1, 2'd1, 1, 8'd1, "rr_1");
    step(0, 4'b1111, 4'b0000, 16'h4321, 4'b0100, 4'h2, 2'd2, 1, 8'd2, "rr_2");
    step(0, 4'b1111, 4'b0000, 16'h4321, 4'b1000, 4'h3, 2'd3, 1, 8'd3, "rr_3");
    step(0, 4'b1111, 4'b0000, 16'h4321, 4'b0001, 4'h4, 2'd0, 1, 8'd4, "rr_4");
    step(0, 4'b1111, 4'b0000, 16'h4321, 4'b0010, 4'h1, 2'd1, 1, 8'd5, "rr_5");
    step(0, 4'b0000, 4'b0000, 16'h4321, 4'b0000, 4'h1, 2'd1, 1, 8'd5, "rr_drop");
    step(1, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'h0, 2'd0, 0, 8'd0, "reset3");

    // Requester 1 locks; forced release after 8 writes hands over to 3.
    step(0, 4'b1010, 4'b0010, 16'h9050, 4'b0010, 4'h0, 2'd1, 0, 8'd0, "lock_gnt");
    for (int k = 1; k <= 7; k++)
      step(0, 4'b1010, 4'b0010, 16'h9050, 4'b0010, 4'h5, 2'd1, 1, 8'(k), "lock_hold");
    step(0, 4'b1010, 4'b0010, 16'h9050, 4'b1000, 4'h5, 2'd3, 1, 8'd8, "lock_force");
    step(0, 4'b1010, 4'b0010, 16'h9050, 4'b0010, 4'h9, 2'd1, 1, 8'd9, "lock_other");
    step(0, 4'b1010, 4'b0010, 16'h9050, 4'b0010, 4'h5, 2'd1, 1, 8'd10, "lock_regain");

    // Reset mid-lock drops the write and clears the pointer.
    step(1, 4'b1010, 4'b0010, 16'h9050, 4'b0000, 4'h0, 2'd0, 0, 8'd0, "rst_mid");
    step(0, 4'b1111, 4'b0000, 16'h4321, 4'b0001, 4'h0, 2'd0, 0, 8'd0, "rst_ptr");
    step(0, 4'b0001, 4'b0000, 16'h4321, 4'b0000, 4'h1, 2'd0, 1, 8'd1, "rst_after");
    step(1, 4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'h0, 2'd0, 0, 8'd0, "reset4");

    // 256 alternating writes wrap wr_count back to 0.
    step(0, 4'b0011, 4'b0000, 16'h0076, 4'b0001, 4'h0, 2'd0, 0, 8'd0, "wrap_gnt");
    for (int n = 1; n <= 256; n++)
      step(0, 4'b0011, 4'b0000, 16'h0076, (n % 2 == 1) ? 4'b0010 : 4'b0001,
           (n % 2 == 1) ? 4'h6 : 4'h7, 2'(n % 2), 1, 8'(n), "wrap");

    bus.req = '0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain %0d expectations left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
